// File: rtl/gb_oam_dma_pkg.sv
// ============================================================================
// Module      : gb_oam_dma_pkg
// Description : Shared constants, state encoding and page-fold helper for the
//               Game Boy OAM DMA engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gb_oam_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } dma_state_e;

    localparam logic [7:0]  DMA_LEN     = 8'd160;
    localparam logic [15:0] DMA_REG_ADR = 16'hFF46;
    localparam logic [15:0] HRAM_LO     = 16'hFF80;
    localparam logic [15:0] HRAM_HI     = 16'hFFFE;
    localparam logic [7:0]  ECHO_BASE   = 8'hE0;
    localparam logic [7:0]  ECHO_FOLD   = 8'h20;

    // Source pages in the echo/IO region alias back onto work RAM.
    function automatic logic [7:0] fold_page(input logic [7:0] page);
        return (page >= ECHO_BASE) ? (page - ECHO_FOLD) : page;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gb_oam_dma.sv
// ============================================================================
// Module      : gb_oam_dma
// Description : OAM DMA engine: copies 160 bytes from {page,00..9F} into OAM,
//               one read and one delayed write per machine cycle.
//               Optional macro GB_OAM_DMA_CPU_BLOCK_EN enables cpu_block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_oam_dma
    import gb_oam_dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] adr,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dw,
    output logic        reg_sel,
    output logic [7:0]  reg_dout,
    output logic [15:0] dma_adr,
    output logic        dma_rd,
    input  logic [7:0]  dma_din,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_dw,
    output logic        oam_wr,
    output logic        active,
    output logic        cpu_block
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic       wr_vld_q, wr_vld_d;
    logic [7:0] wr_idx_q, wr_idx_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       keep_q, keep_d;

    logic w_reg_wr;
    logic w_rd;

    assign reg_sel  = (adr == DMA_REG_ADR);
    assign w_reg_wr = ce & cpu_wr & reg_sel;
    // A restart write aborts the read that would otherwise happen this cycle.
    assign w_rd     = ce & (state_q == ST_XFER) & ~w_reg_wr;

    assign reg_dout = page_q;
    assign dma_rd   = w_rd;
    assign dma_adr  = {fold_page(page_q), index_q};
    assign oam_wr   = ce & wr_vld_q;
    assign oam_adr  = wr_idx_q;
    assign oam_dw   = wr_data_q;
    assign active   = (state_q == ST_XFER) | wr_vld_q |
                      ((state_q == ST_START) & keep_q);

`ifdef GB_OAM_DMA_CPU_BLOCK_EN
    logic w_hram;
    assign w_hram    = (adr >= HRAM_LO) && (adr <= HRAM_HI);
    assign cpu_block = active & ~w_hram & ~reg_sel;
`else
    assign cpu_block = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        index_d   = index_q;
        wr_vld_d  = wr_vld_q;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        keep_d    = keep_q;
        if (ce) begin
            wr_vld_d = w_rd;
            if (w_rd) begin
                wr_idx_d  = index_q;
                wr_data_d = dma_din;
            end
            case (state_q)
                ST_START: begin
                    state_d = ST_XFER;
                    index_d = 8'd0;
                    keep_d  = 1'b0;
                end
                ST_XFER: begin
                    index_d = index_q + 8'd1;
                    if (index_q == DMA_LEN - 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
            // Remember whether we were mid-transfer so active stays up through START.
            if (w_reg_wr) begin
                page_d  = cpu_dw;
                state_d = ST_START;
                keep_d  = active;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            page_q    <= 8'd0;
            index_q   <= 8'd0;
            wr_vld_q  <= 1'b0;
            wr_idx_q  <= 8'd0;
            wr_data_q <= 8'd0;
            keep_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            index_q   <= index_d;
            wr_vld_q  <= wr_vld_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            keep_q    <= keep_d;
        end
    end

endmodule

`default_nettype wire
